// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - normalise and round-to-nearest-even a raw FP sum
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      vld_i,
    output logic                      rdy_o,
    input  logic                      sign_i,
    input  logic [EXP_W-1:0]          exp_i,
    input  logic [MANT_W+1:0]         mant_i,
    input  logic [2:0]                grs_i,
    input  logic                      special_i,
    output logic                      vld_o,
    input  logic                      rdy_i,
    output logic [EXP_W+MANT_W:0]     res_o,
    output logic                      status_o
);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [EXP_W-1:0]        exp_q, exp_d;
    logic [MANT_W+1:0]       mant_q, mant_d;
    logic [2:0]              grs_q, grs_d;
    logic [EXP_W+MANT_W:0]   res_q, res_d;
    logic                    status_q, status_d;
    logic                    vld_q, vld_d;

    logic [EXP_W:0]          exp_wide;
    logic [EXP_W-1:0]        exp_inc_sat;
    logic                    inc;
    logic [MANT_W+1:0]       rsum;
    logic [MANT_W-1:0]       frac_r;
    logic [EXP_W-1:0]        exp_r;

    assign rdy_o    = rst_ni && (state_q == IDLE);
    assign vld_o    = vld_q;
    assign res_o    = res_q;
    assign status_o = status_q;

    // Exponent increment saturates at all ones so overflow always lands on infinity.
    always_comb begin
        exp_wide    = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
        exp_inc_sat = (exp_wide >= {1'b0, EXP_ONES}) ? EXP_ONES : exp_wide[EXP_W-1:0];
        inc         = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
        rsum        = {1'b0, mant_q[MANT_W:0]} + {{(MANT_W+1){1'b0}}, inc};
        if (rsum[MANT_W+1]) begin
            frac_r = rsum[MANT_W:1];
            exp_r  = exp_inc_sat;
        end else begin
            frac_r = rsum[MANT_W-1:0];
            exp_r  = (exp_q == '0 && rsum[MANT_W]) ? EXP_ONE : exp_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        grs_d    = grs_q;
        res_d    = res_q;
        status_d = status_q;
        vld_d    = vld_q;
        case (state_q)
            IDLE: begin
                if (vld_i) begin
                    sign_d = sign_i;
                    exp_d  = exp_i;
                    mant_d = mant_i;
                    grs_d  = grs_i;
                    if (special_i) begin
                        res_d    = {sign_i, EXP_ONES, mant_i[MANT_W-1:0]};
                        status_d = 1'b1;
                        vld_d    = 1'b1;
                        state_d  = DONE;
                    end else if (mant_i == '0 && grs_i == 3'b000) begin
                        res_d    = {sign_i, {(EXP_W+MANT_W){1'b0}}};
                        status_d = 1'b0;
                        vld_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mant_q[MANT_W+1]) begin
                    mant_d  = {1'b0, mant_q[MANT_W+1:1]};
                    grs_d   = {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
                    exp_d   = exp_inc_sat;
                    state_d = ROUND;
                end else if (mant_q[MANT_W]) begin
                    state_d = ROUND;
                end else if (exp_q > EXP_ONE) begin
                    mant_d = {mant_q[MANT_W:0], grs_q[2]};
                    grs_d  = {grs_q[1], 1'b0, grs_q[0]};
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    exp_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (exp_r == EXP_ONES) begin
                    res_d    = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
                    status_d = 1'b1;
                end else begin
                    res_d    = {sign_q, exp_r, frac_r};
                    status_d = 1'b0;
                end
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (rdy_i) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            grs_q    <= '0;
            res_q    <= '0;
            status_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            grs_q    <= grs_d;
            res_q    <= res_d;
            status_q <= status_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - directed-vector bench for fp_norm_round
module tb_fp_norm_round;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        vld_i;
    logic        rdy_o;
    logic        sign_i;
    logic [7:0]  exp_i;
    logic [24:0] mant_i;
    logic [2:0]  grs_i;
    logic        special_i;
    logic        vld_o;
    logic        rdy_i;
    logic [31:0] res_o;
    logic        status_o;

    int total = 0;
    int bad   = 0;

    fp_norm_round dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .vld_i     (vld_i),
        .rdy_o     (rdy_o),
        .sign_i    (sign_i),
        .exp_i     (exp_i),
        .mant_i    (mant_i),
        .grs_i     (grs_i),
        .special_i (special_i),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i),
        .res_o     (res_o),
        .status_o  (status_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!rdy_o && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!rdy_o) check({tag, "_rdy_timeout"}, {31'd0, rdy_o}, 32'd1);
    endtask

    task automatic accept(input logic s, input logic [7:0] e, input logic [24:0] m,
                          input logic [2:0] g, input logic sp);
        sign_i    = s;
        exp_i     = e;
        mant_i    = m;
        grs_i     = g;
        special_i = sp;
        vld_i     = 1'b1;
        @(posedge clk_i);
        #1;
        vld_i     = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input logic [2:0] g, input logic sp,
                           input logic [31:0] exp_res, input logic exp_st, input int exp_lat);
        int lat;
        wait_ready(tag);
        accept(s, e, m, g, sp);
        lat = 1;
        while (!vld_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, res_o, exp_res);
        check({tag, "_st"}, {31'd0, status_o}, {31'd0, exp_st});
        rdy_i = 1'b1;
        @(posedge clk_i);
        #1;
        rdy_i = 1'b0;
        check({tag, "_vld_drop"}, {31'd0, vld_o}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] held;
        rst_ni    = 1'b0;
        vld_i     = 1'b0;
        rdy_i     = 1'b0;
        sign_i    = 1'b0;
        exp_i     = '0;
        mant_i    = '0;
        grs_i     = '0;
        special_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_vld", {31'd0, vld_o}, 32'd0);
        check("rst_res", res_o, 32'd0);
        check("rst_st", {31'd0, status_o}, 32'd0);
        check("rst_rdy_low", {31'd0, rdy_o}, 32'd0);
        rst_ni = 1'b1;
        #1;
        check("rst_rdy_first", {31'd0, rdy_o}, 32'd1);

        run_vec("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 1'b0, 32'h40000000, 1'b0, 3);
        run_vec("cancel",       1'b0, 8'd127, 25'h0400000, 3'b000, 1'b0, 32'h3F000000, 1'b0, 4);
        run_vec("tie_odd",      1'b0, 8'd127, 25'h0800001, 3'b100, 1'b0, 32'h3F800002, 1'b0, 3);
        run_vec("tie_even",     1'b0, 8'd127, 25'h0800000, 3'b100, 1'b0, 32'h3F800000, 1'b0, 3);
        run_vec("overflow",     1'b0, 8'd254, 25'h1000000, 3'b000, 1'b0, 32'h7F800000, 1'b1, 3);
        run_vec("neg_zero",     1'b1, 8'd0,   25'h0000000, 3'b000, 1'b0, 32'h80000000, 1'b0, 1);
        run_vec("special",      1'b0, 8'd3,   25'h0400001, 3'b000, 1'b1, 32'h7FC00001, 1'b1, 1);
        run_vec("rnd_carry",    1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 1'b0, 32'h40000000, 1'b0, 3);
        run_vec("rshift_rnd",   1'b0, 8'd127, 25'h1000003, 3'b000, 1'b0, 32'h40000002, 1'b0, 3);
        run_vec("denorm",       1'b0, 8'd1,   25'h0200000, 3'b000, 1'b0, 32'h00200000, 1'b0, 3);
        run_vec("denorm_up",    1'b0, 8'd1,   25'h07FFFFF, 3'b100, 1'b0, 32'h00800000, 1'b0, 3);
        run_vec("guard_in",     1'b0, 8'd127, 25'h0400000, 3'b100, 1'b0, 32'h3F000001, 1'b0, 4);
        run_vec("shift23",      1'b1, 8'd127, 25'h0000001, 3'b000, 1'b0, 32'hB4000000, 1'b0, 26);

        // Backpressure: result must hold while downstream stalls.
        wait_ready("bp");
        accept(1'b0, 8'd127, 25'h1000000, 3'b000, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check("bp_vld_up", {31'd0, vld_o}, 32'd1);
        held = res_o;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            if (vld_o !== 1'b1 || res_o !== 32'h40000000) seen++;
        end
        check("bp_held", seen, 0);
        check("bp_res", held, 32'h40000000);
        check("bp_rdy_busy", {31'd0, rdy_o}, 32'd0);
        rdy_i = 1'b1;
        @(posedge clk_i);
        #1;
        rdy_i = 1'b0;
        check("bp_release", {31'd0, vld_o}, 32'd0);

        // Reset mid-normalisation aborts the transaction.
        wait_ready("rstmid");
        accept(1'b0, 8'd127, 25'h0000001, 3'b000, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("rstmid_vld", {31'd0, vld_o}, 32'd0);
        check("rstmid_res", res_o, 32'd0);
        rst_ni = 1'b1;
        #1;
        check("rstmid_rdy", {31'd0, rdy_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (vld_o) seen++;
        end
        check("rstmid_no_result", seen, 0);

        run_vec("after_rst", 1'b0, 8'd127, 25'h1000000, 3'b000, 1'b0, 32'h40000000, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MANT_W, default 23, stored fraction width; hidden bit not stored.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 vld_i  input  1  raw sum valid, from the FP summator stage.
REQ-006 rdy_o  output  1  block can accept a raw sum.
REQ-007 sign_i  input  1  raw sum sign.
REQ-008 exp_i  input  EXP_W  raw sum biased exponent.
REQ-009 mant_i  input  MANT_W+2  raw magnitude: bit MANT_W+1 carry, bit MANT_W hidden, low bits fraction.
REQ-010 grs_i  input  3  guard, round, sticky bits below the fraction LSB.
REQ-011 special_i  input  1  1 = operand NaN/Inf; result passes through as special.
REQ-012 vld_o  output  1  result valid.
REQ-013 rdy_i  input  1  downstream accepts result.
REQ-014 res_o  output  1+EXP_W+MANT_W  packed {sign, exp, fraction} IEEE-style result.
REQ-015 status_o  output  1  1 = result exponent all ones (NaN/Inf/overflow).

Function
REQ-016 States: IDLE, NORM, ROUND, DONE; rdy_o = 1 only in IDLE and only when rst_ni = 1.
REQ-017 Accept on vld_i & rdy_o: capture all inputs; special_i or (mant_i = 0 and grs_i = 0) -> DONE, else -> NORM.
REQ-018 Special capture: exponent all ones, sign and low MANT_W bits of mant_i passed through, status_o = 1.
REQ-019 Zero capture: exponent 0, fraction 0, sign preserved, status_o = 0.
REQ-020 NORM, carry = 1: shift magnitude right 1, old LSB into guard, old guard into round, sticky |= old round | old sticky, exp + 1, -> ROUND.
REQ-021 NORM, carry = 0, hidden = 1: -> ROUND, no change.
REQ-022 NORM, carry = 0, hidden = 0, exp > 1: shift left 1, guard into LSB, round into guard, round <= 0, sticky unchanged, exp - 1, stay in NORM.
REQ-023 NORM, hidden = 0, exp <= 1: denormal; -> ROUND with exp forced to 0.
REQ-024 One shift per cycle; k left shifts occupy k+1 NORM cycles; k <= MANT_W+1.
REQ-025 ROUND: round-to-nearest-even, inc = G & (R | S | LSB); 24-bit {hidden, fraction} + inc.
REQ-026 Round carry-out: shift right 1, exp + 1; denormal rounding into hidden = 1 sets exp to 1.
REQ-027 Any exponent reaching all ones in NORM or ROUND: result = signed infinity (fraction 0), status_o = 1.
REQ-028 ROUND -> DONE; DONE drives vld_o = 1 with res_o/status_o stable until vld_o & rdy_i, then -> IDLE.
REQ-029 Latency from accept edge to vld_o: 1 cycle for special/zero; 3 + k cycles for k left shifts; 3 cycles for carry case.
REQ-030 No new accept while a result is held; throughput one result per completed transaction.
REQ-031 rdy_i ignored outside DONE; vld_i ignored outside IDLE.

Reset
REQ-032 While rst_ni = 0 at a clock edge: state <= IDLE, vld_o = 0, res_o = 0, status_o = 0, captured registers cleared.
REQ-033 Reset in any state, including mid-NORM or DONE with rdy_i = 0, aborts the transaction; no result is emitted for it.
REQ-034 rdy_o = 1 in the first cycle with rst_ni = 1 after reset.

Verification (EXP_W = 8, MANT_W = 23)
REQ-035 1.0 + 1.0: mant_i = 25'h1000000, exp_i = 127, grs 0 -> res_o = 32'h40000000, vld_o 3 cycles after accept.
REQ-036 Cancellation: mant_i = 25'h0400000, exp_i = 127 -> res_o = 32'h3F000000 at 4 cycles.
REQ-037 Ties: mant_i = 25'h0800001, grs = 3'b100, exp 127 -> 32'h3F800002; mant_i = 25'h0800000, grs = 3'b100 -> 32'h3F800000.
REQ-038 Overflow: mant_i = 25'h1000000, exp_i = 254 -> res_o = 32'h7F800000, status_o = 1.
REQ-039 Zero: sign_i = 1, mant_i = 0, grs 0 -> res_o = 32'h80000000 at 1 cycle; special_i = 1 -> exp all ones, status_o = 1.
REQ-040 Backpressure and reset: rdy_i = 0 for 5 cycles holds res_o and vld_o; rst_ni = 0 during NORM -> vld_o = 0, rdy_o = 1 after release.
